// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM encoding and default address constants.
package cpu_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;
    localparam int          PC_STEP      = 4;

    typedef enum logic [1:0] {
        BOOT,
        ISSUE,
        WAIT,
        FULL
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a time and
// hands each instruction to decode through a single valid/ready slot.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int             XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEF_TRAP_VEC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    input  logic            trap_valid,
    output logic [XLEN-1:0] pc_out
);

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_addr_q;
    logic            kill_q;
    logic [XLEN-1:0] if_pc_q;
    logic [XLEN-1:0] if_instr_q;

    logic            redirect;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target_d;

    // Trap outranks a simultaneous branch redirect; targets are word aligned.
    assign redirect   = trap_valid | redir_valid;
    assign target_raw = trap_valid ? TRAP_VEC : redir_pc;
    assign target_d   = {target_raw[XLEN-1:2], 2'b00};

    assign imem_req  = (state_q == ISSUE) || (state_q == WAIT);
    assign imem_addr = (state_q == ISSUE) ? pc_q : req_addr_q;
    assign if_valid  = (state_q == FULL);
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign pc_out    = pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            kill_q     <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= ISSUE;
                    if (redirect) pc_q <= target_d;
                end
                ISSUE: begin
                    req_addr_q <= pc_q;
                    if (imem_ack) begin
                        if (redirect) begin
                            pc_q    <= target_d;
                            state_q <= ISSUE;
                        end else begin
                            if_instr_q <= imem_rdata;
                            if_pc_q    <= pc_q;
                            pc_q       <= pc_q + XLEN'(PC_STEP);
                            state_q    <= FULL;
                        end
                    end else begin
                        // Request stays on the bus; a redirect now only marks it stale.
                        if (redirect) begin
                            kill_q <= 1'b1;
                            pc_q   <= target_d;
                        end
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        if (kill_q || redirect) begin
                            kill_q  <= 1'b0;
                            if (redirect) pc_q <= target_d;
                            state_q <= ISSUE;
                        end else begin
                            if_instr_q <= imem_rdata;
                            if_pc_q    <= req_addr_q;
                            pc_q       <= req_addr_q + XLEN'(PC_STEP);
                            state_q    <= FULL;
                        end
                    end else if (redirect) begin
                        kill_q <= 1'b1;
                        pc_q   <= target_d;
                    end
                end
                FULL: begin
                    if (redirect) begin
                        pc_q    <= target_d;
                        state_q <= ISSUE;
                    end else if (if_ready) begin
                        state_q <= ISSUE;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run against a
// stream-level model (next delivered PC, memory contents as a function of address).
module tb_fetch_sequencer;
    import cpu_pkg::*;

    localparam logic [31:0] RPC  = DEF_RESET_PC;
    localparam logic [31:0] TVEC = DEF_TRAP_VEC;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid, if_ready;
    logic [31:0] if_pc, if_instr;
    logic        redir_valid, trap_valid;
    logic [31:0] redir_pc, pc_out;

    fetch_sequencer dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .trap_valid(trap_valid), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int          lat_sel   = 0;
    int          slow_lat  = 0;
    int          lat_left  = -1;
    logic [31:0] slow_addr = 32'h1;
    logic [31:0] exp_pc    = RPC;

    logic        p_valid, p_ready, p_redir, p_req, p_ack;
    logic [31:0] p_tgt, p_addr, p_ifpc, p_instr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock: snapshot what the edge will see, advance the stream model, then
    // play the memory side for the new cycle.
    task automatic step();
        p_redir = rst && (redir_valid || trap_valid);
        p_tgt   = trap_valid ? TVEC : {redir_pc[31:2], 2'b00};
        p_valid = if_valid;  p_ready = if_ready;
        p_req   = imem_req;  p_ack   = imem_ack;  p_addr = imem_addr;
        p_ifpc  = if_pc;     p_instr = if_instr;
        @(posedge clk); #1;
        if (!rst)                    exp_pc = RPC;
        else if (p_redir)            exp_pc = p_tgt;
        else if (p_valid && p_ready) exp_pc = exp_pc + 32'd4;
        if (p_req && !p_ack) lat_left--;
        else                 lat_left = -1;
        redir_valid = 1'b0;
        trap_valid  = 1'b0;
        if (imem_req) begin
            if (lat_left < 0)
                lat_left = (imem_addr == slow_addr) ? slow_lat :
                           (lat_sel >= 0 ? lat_sel : int'($urandom_range(0, 3)));
            imem_ack   = (lat_left == 0);
            imem_rdata = memf(imem_addr);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            lat_left   = -1;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b0; redir_valid = 1'b0; trap_valid = 1'b0; slow_addr = 32'h1;
        step(); step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        n_tests++;
        if ({imem_req, imem_addr, if_valid, if_pc, if_instr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b addr=%h vld=%b pc=%h instr=%h, all must be 0",
                     imem_req, imem_addr, if_valid, if_pc, if_instr);
        end
        n_tests++;
        if (pc_out !== RPC) begin
            n_fail++; $display("FAIL reset_pc_out: got %h exp %h", pc_out, RPC);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] addrs[$];
        int          cycs[$];
        reset_dut(); lat_sel = 0; if_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (imem_req) begin addrs.push_back(imem_addr); cycs.push_back(c); end
            if (if_valid && !p_valid) begin
                n_tests++;
                if (if_pc !== exp_pc || if_instr !== memf(exp_pc)) begin
                    n_fail++;
                    $display("FAIL zw_slot: pc=%h instr=%h exp pc=%h instr=%h", if_pc, if_instr, exp_pc, memf(exp_pc));
                end
            end
        end
        n_tests++;
        if (addrs.size() < 3) begin
            n_fail++; $display("FAIL zw_count: got %0d requests exp >=3", addrs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (addrs[i] !== 32'(4 * i) || cycs[i] != cycs[0] + 2 * i) begin
                    n_fail++;
                    $display("FAIL zw_addr%0d: addr=%h cyc=%0d exp addr=%h cyc=%0d", i, addrs[i], cycs[i], 4 * i, cycs[0] + 2 * i);
                end
            end
        end
    endtask

    task automatic test_latency();
        int k;
        reset_dut(); lat_sel = 0; if_ready = 1'b1; slow_addr = 32'h8; slow_lat = 2;
        k = 0;
        while (!(imem_req && imem_addr == 32'h8) && k < 20) begin step(); k++; end
        n_tests++;
        if (k >= 20) begin n_fail++; $display("FAIL lat_reach: no request to 00000008 in 20 cycles"); end
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_valid !== 1'b0) begin
                n_fail++; $display("FAIL lat_hold%0d: req=%b addr=%h vld=%b exp 1/00000008/0", c, imem_req, imem_addr, if_valid);
            end
            step();
        end
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== memf(32'h8)) begin
            n_fail++; $display("FAIL lat_deliver: vld=%b pc=%h instr=%h exp 1/00000008/%h", if_valid, if_pc, if_instr, memf(32'h8));
        end
    endtask

    task automatic test_redirect_wait();
        int          k;
        logic [31:0] next_addr;
        logic        seen_dead, got_next;
        reset_dut(); lat_sel = 0; if_ready = 1'b1; slow_addr = 32'h8; slow_lat = 3;
        k = 0;
        while (!(imem_req && imem_addr == 32'h8) && k < 20) begin step(); k++; end
        step();
        redir_valid = 1'b1; redir_pc = 32'h40;
        seen_dead = 1'b0; got_next = 1'b0; next_addr = '0;
        for (int c = 0; c < 10; c++) begin
            if (imem_addr == 32'h8) imem_rdata = 32'hDEAD;
            step();
            if (if_valid && if_instr == 32'hDEAD) seen_dead = 1'b1;
            if (imem_req && imem_addr != 32'h8 && !got_next) begin got_next = 1'b1; next_addr = imem_addr; end
        end
        n_tests++;
        if (seen_dead) begin n_fail++; $display("FAIL rw_killed: got DEAD presented exp never"); end
        n_tests++;
        if (!got_next || next_addr !== 32'h40) begin
            n_fail++; $display("FAIL rw_next: got %h (seen=%b) exp 00000040", next_addr, got_next);
        end
    endtask

    task automatic test_trap_full();
        int k;
        reset_dut(); lat_sel = 0; if_ready = 1'b0;
        k = 0;
        while (!if_valid && k < 20) begin step(); k++; end
        trap_valid = 1'b1; redir_valid = 1'b1; redir_pc = 32'h80;
        step();
        n_tests++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== TVEC || pc_out !== TVEC) begin
            n_fail++;
            $display("FAIL trap_full: vld=%b req=%b addr=%h pc_out=%h exp 0/1/%h/%h", if_valid, imem_req, imem_addr, pc_out, TVEC, TVEC);
        end
    endtask

    task automatic test_stall();
        int          k;
        logic [31:0] spc, sins;
        reset_dut(); lat_sel = 0; if_ready = 1'b0;
        k = 0;
        while (!if_valid && k < 20) begin step(); k++; end
        spc = if_pc; sins = if_instr;
        for (int c = 0; c < 5; c++) begin
            step();
            n_tests++;
            if (if_valid !== 1'b1 || if_pc !== spc || if_instr !== sins || imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall%0d: vld=%b pc=%h instr=%h req=%b exp 1/%h/%h/0", c, if_valid, if_pc, if_instr, imem_req, spc, sins);
            end
        end
        if_ready = 1'b1;
        step();
        n_tests++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== spc + 32'd4) begin
            n_fail++; $display("FAIL stall_release: vld=%b req=%b addr=%h exp 0/1/%h", if_valid, imem_req, imem_addr, spc + 32'd4);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] addrs[$];
        reset_dut(); lat_sel = 0; if_ready = 1'b1;
        redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFF;
        for (int c = 0; c < 6; c++) begin
            step();
            if (imem_req) addrs.push_back(imem_addr);
            if (if_valid && !p_valid) begin
                n_tests++;
                if (if_pc !== exp_pc || if_instr !== memf(exp_pc)) begin
                    n_fail++; $display("FAIL wrap_slot: pc=%h exp %h", if_pc, exp_pc);
                end
            end
        end
        n_tests++;
        if (addrs.size() < 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_addrs: got %0d reqs first=%h second=%h exp FFFFFFFC then 00000000",
                     addrs.size(), addrs.size() > 0 ? addrs[0] : 32'hX, addrs.size() > 1 ? addrs[1] : 32'hX);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut(); lat_sel = 3; if_ready = 1'b1;
        step(); step(); step();
        n_tests++;
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rm_pre: req=%b exp 1", imem_req); end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({imem_req, imem_addr, if_valid, if_pc, if_instr} !== '0 || pc_out !== RPC) begin
            n_fail++;
            $display("FAIL reset_mid: req=%b addr=%h vld=%b pc=%h instr=%h pc_out=%h exp zeros/%h",
                     imem_req, imem_addr, if_valid, if_pc, if_instr, pc_out, RPC);
        end
    endtask

    task automatic test_random();
        int r;
        int n_del;
        reset_dut(); lat_sel = -1; n_del = 0;
        for (int c = 0; c < 3000; c++) begin
            if_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 6)           begin redir_valid = 1'b1; redir_pc = $urandom; end
            if (r >= 4 && r < 9) trap_valid = 1'b1;
            step();
            if (if_valid && !p_valid) begin
                n_del++; n_tests++;
                if (if_pc !== exp_pc || if_instr !== memf(exp_pc)) begin
                    n_fail++; $display("FAIL rnd_slot c%0d: pc=%h instr=%h exp %h/%h", c, if_pc, if_instr, exp_pc, memf(exp_pc));
                end
            end
            if (p_valid && !p_ready && !p_redir) begin
                n_tests++;
                if (if_valid !== 1'b1 || if_pc !== p_ifpc || if_instr !== p_instr) begin
                    n_fail++; $display("FAIL rnd_hold c%0d: vld=%b pc=%h exp 1/%h", c, if_valid, if_pc, p_ifpc);
                end
            end
            if (p_req && !p_ack) begin
                n_tests++;
                if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
                    n_fail++; $display("FAIL rnd_req_hold c%0d: req=%b addr=%h exp 1/%h", c, imem_req, imem_addr, p_addr);
                end
            end
            n_tests++;
            if (if_valid && imem_req) begin
                n_fail++; $display("FAIL rnd_one_out c%0d: vld=1 req=1 exp no request while full", c);
            end
        end
        n_tests++;
        if (n_del < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d deliveries exp >=100", n_del); end
    endtask

    initial begin
        rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        redir_valid = 1'b0; trap_valid = 1'b0; redir_pc = '0;
        test_reset();
        test_zero_wait();
        test_latency();
        test_redirect_wait();
        test_trap_full();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch for the single-issue core: owns the program counter and issues one request at a time to instruction memory.
- Delivers each fetched instruction to decode over a valid/ready slot.
- Applies branch/jump redirects and traps, including the case where a redirect lands while a fetch is still outstanding.
- Sits between imem and decode; EX drives redirects, the trap unit drives trap_valid.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- TRAP_VEC, 32'h0000_0100, fetch target on trap.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  XLEN  fetch address; stable while imem_req high
- imem_ack  in  1  response valid, same cycle as data; may arrive in the first request cycle
- imem_rdata  in  XLEN  instruction word
- if_valid  out  1  instruction slot full
- if_ready  in  1  decode accepts the slot
- if_pc  out  XLEN  address of if_instr
- if_instr  out  XLEN  fetched instruction
- redir_valid  in  1  branch/jump redirect pulse
- redir_pc  in  XLEN  redirect target
- trap_valid  in  1  trap pulse; target TRAP_VEC
- pc_out  out  XLEN  current next-fetch PC, for debug

Behaviour:
- Reset (rst=0, async): state=BOOT, pc=RESET_PC, req_addr=0, kill=0, if_pc=0, if_instr=0. All outputs are 0 except pc_out=RESET_PC.
- Redirect event: redirect = trap_valid | redir_valid. Target = TRAP_VEC if trap_valid, else redir_pc; trap wins when both are high. Target bits [1:0] are forced to 0.
- BOOT: always goes to ISSUE next cycle. If a redirect occurs here, pc<=target.
- ISSUE (slot empty):
  - imem_req=1, imem_addr=pc; req_addr<=pc.
  - ack and no redirect: if_instr<=rdata, if_pc<=pc, pc<=pc+4 → FULL.
  - ack with redirect: data dropped, pc<=target → ISSUE.
  - no ack: if redirect, kill<=1 and pc<=target → WAIT.
- WAIT:
  - imem_req=1, imem_addr=req_addr. Address is never changed mid-request.
  - ack and !kill and no redirect: capture as in ISSUE (if_pc<=req_addr, pc<=req_addr+4) → FULL.
  - ack and (kill or redirect): data dropped, kill<=0; if redirect, pc<=target → ISSUE.
  - no ack and redirect: kill<=1, pc<=target. A later redirect overwrites pc.
- FULL:
  - if_valid=1; imem_req=0.
  - redirect: slot flushed, pc<=target → ISSUE. The flush wins over if_ready; decode still treats a same-cycle if_ready as accepted.
  - else if if_ready → ISSUE.
  - else hold; if_pc and if_instr stay stable.
- if_valid is 1 exactly when state==FULL, so it is registered via the state.
- Throughput: one instruction per 2 cycles at zero wait states. A new request starts only when the slot is empty.
- pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC → 0).
- Redirect on the same cycle as if_ready in FULL: target fetched next, no sequential fetch issued.
- Reset asserted mid-request: abandons everything. imem must tolerate req dropping without ack on reset.

Decomposition:
- Shared package (cpu_pkg):
  - state enum fetch_state_t {BOOT, ISSUE, WAIT, FULL};
  - XLEN, RESET_PC and TRAP_VEC defaults;
  - PC_STEP=4.
- Single module, no sub-module. The PC register and req_addr are internal flops; target muxing is inline.

Test Plan:
- Reset release, imem_ack tied to imem_req, if_ready=1 → addresses 0x0, 0x4, 0x8 issued on every other cycle; if_pc matches each rdata.
- 3-cycle ack latency at addr 0x8 → imem_req and imem_addr=0x8 stable all 3 cycles; if_valid high the cycle after ack.
- redir_valid with redir_pc=0x40 on WAIT cycle 1, ack 2 cycles later with rdata=0xDEAD → 0xDEAD never presented; next request addr=0x40.
- trap_valid and redir_valid (0x80) together while FULL with if_ready=0 → slot flushed next cycle; next imem_addr=0x100.
- if_ready=0 for 5 cycles in FULL → if_valid, if_pc and if_instr constant, no imem_req; if_ready=1 → request issued next cycle.
- Redirect to 0xFFFF_FFFC, zero-wait → fetches 0xFFFF_FFFC then 0x0. Also drive rst low during WAIT → all outputs 0 and pc_out=RESET_PC immediately.
